// File: rtl/nios_system_button_in.sv
`default_nettype none
// ============================================================================
// nios_system_button_in : Avalon-MM button input PIO (sync, debounce, edge IRQ)
// Revision 1.0
// ============================================================================
module nios_system_button_in #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16,
   parameter bit INVERT          = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync1_d;
   logic [WIDTH-1:0] sync2_q, sync2_d;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
   logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];

   logic [WIDTH-1:0] pin;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] clr_mask;
   logic             wr_en;
   logic             unused_wdata;

   // Only the low WIDTH bits of writedata are meaningful.
   assign unused_wdata = &{1'b0, writedata};

   always_comb begin
      pin      = in_port ^ {WIDTH{INVERT}};
      sync1_d  = pin;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         // Any sample matching the accepted level restarts the qualification window.
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == C_CNT_LAST) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end

      rise     = stable_d & ~stable_q;
      wr_en    = chipselect & ~write_n;
      clr_mask = (wr_en && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;
      // A press accepted on the same edge as a clear must survive.
      edge_cap_d = (edge_cap_q & ~clr_mask) | rise;
      irq_mask_d = (wr_en && (address == 2'd2)) ? writedata[WIDTH-1:0] : irq_mask_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         stable_q   <= '0;
         edge_cap_q <= '0;
         irq_mask_q <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         stable_q   <= stable_d;
         edge_cap_q <= edge_cap_d;
         irq_mask_q <= irq_mask_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata[WIDTH-1:0] = stable_q;
         2'd2:    readdata[WIDTH-1:0] = irq_mask_q;
         2'd3:    readdata[WIDTH-1:0] = edge_cap_q;
         default: readdata = '0;
      endcase
   end

   assign irq = |(edge_cap_q & irq_mask_q);

endmodule
`default_nettype wire
